// File: rtl/hyper_pkg.sv
// Shared types for the HyperBus transaction arbiter: FSM states, payload layout, width helper.
package hyper_pkg;

  localparam int unsigned DefAddrWidth  = 32;
  localparam int unsigned DefBurstWidth = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0]  addr;
    logic                     write;
    logic [DefBurstWidth-1:0] burst;
  } hyper_trx_t;

  // Index width that stays at least one bit wide for single-entry vectors.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hyper_rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr_i, wrapping modulo NumReq.
module hyper_rr_pick
  import hyper_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned PtrW   = clog2_min1(NumReq)
) (
  input  logic [PtrW-1:0]   rr_ptr_i,
  input  logic [NumReq-1:0] valid_i,
  output logic [NumReq-1:0] sel_oh_o,
  output logic [PtrW-1:0]   sel_idx_o,
  output logic              any_o
);

  logic        found;
  int unsigned j;

  always_comb begin
    sel_oh_o  = '0;
    sel_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      j = (32'(rr_ptr_i) + i) % NumReq;
      if (!found && valid_i[PtrW'(j)]) begin
        found                 = 1'b1;
        sel_oh_o[PtrW'(j)]    = 1'b1;
        sel_idx_o             = PtrW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/hyper_trx_arbiter.sv
// Round-robin arbiter sharing one HyperBus PHY transaction port, with chip-select decode
// and an enforced CS-high gap between transactions.
module hyper_trx_arbiter
  import hyper_pkg::*;
#(
  parameter  int unsigned NumReq     = 2,
  parameter  int unsigned AddrWidth  = DefAddrWidth,
  parameter  int unsigned BurstWidth = DefBurstWidth,
  parameter  int unsigned NumChips   = 2,
  parameter  int unsigned CsHiCycles = 2,
  localparam int unsigned PtrW       = clog2_min1(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [4:0]                   cfg_cs_shift_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]  req_addr_i,
  input  logic [NumReq-1:0]            req_write_i,
  input  logic [NumReq*BurstWidth-1:0] req_burst_i,
  output logic                         phy_valid_o,
  input  logic                         phy_ready_i,
  output logic [AddrWidth-1:0]         phy_addr_o,
  output logic                         phy_write_o,
  output logic [BurstWidth-1:0]        phy_burst_o,
  output logic [NumChips-1:0]          phy_cs_o,
  input  logic                         phy_done_i,
  output logic [PtrW-1:0]              grant_id_o,
  output logic                         busy_o
);

  localparam int unsigned IdxW = clog2_min1(NumChips);
  localparam int unsigned CntW = clog2_min1(CsHiCycles + 1);

  typedef struct packed {
    logic [AddrWidth-1:0]  addr;
    logic                  write;
    logic [BurstWidth-1:0] burst;
  } trx_t;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  trx_t                trx_q, trx_d;
  logic [PtrW-1:0]     gid_q, gid_d;
  logic [NumChips-1:0] cs_q, cs_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [NumReq-1:0]   sel_oh;
  logic [PtrW-1:0]     sel_idx;
  logic                any_valid;
  trx_t                cand;
  logic [IdxW-1:0]     cs_idx;
  logic [NumChips-1:0] cs_new;

  hyper_rr_pick #(
    .NumReq (NumReq),
    .PtrW   (PtrW)
  ) u_pick (
    .rr_ptr_i  (rr_ptr_q),
    .valid_i   (req_valid_i),
    .sel_oh_o  (sel_oh),
    .sel_idx_o (sel_idx),
    .any_o     (any_valid)
  );

  // Candidate payload and its clamped one-hot chip select, valid only in the latch cycle.
  always_comb begin
    cand.addr  = req_addr_i[32'(sel_idx)*AddrWidth +: AddrWidth];
    cand.write = req_write_i[sel_idx];
    cand.burst = req_burst_i[32'(sel_idx)*BurstWidth +: BurstWidth];
    cs_idx     = IdxW'(cand.addr >> cfg_cs_shift_i);
    if (32'(cs_idx) >= NumChips) cs_idx = IdxW'(NumChips - 1);
    cs_new     = NumChips'(1) << cs_idx;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    trx_d    = trx_q;
    gid_d    = gid_q;
    cs_d     = cs_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          trx_d    = cand;
          gid_d    = sel_idx;
          cs_d     = cs_new;
          rr_ptr_d = PtrW'((32'(sel_idx) + 1) % NumReq);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (phy_ready_i) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (phy_done_i) begin
          if (CsHiCycles > 0) begin
            state_d = ST_GAP;
            cnt_d   = CntW'(CsHiCycles - 1);
          end else begin
            state_d = ST_IDLE;
            cs_d    = '0;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cs_d    = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      trx_q    <= '0;
      gid_q    <= '0;
      cs_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      trx_q    <= trx_d;
      gid_q    <= gid_d;
      cs_q     <= cs_d;
      cnt_q    <= cnt_d;
    end
  end

  // Accept pulse is the only combinational output; it is masked while reset is held.
  assign req_ready_o = (rst_ni && state_q == ST_IDLE) ? sel_oh : '0;
  assign phy_valid_o = (state_q == ST_ISSUE);
  assign busy_o      = (state_q != ST_IDLE);
  assign phy_addr_o  = trx_q.addr;
  assign phy_write_o = trx_q.write;
  assign phy_burst_o = trx_q.burst;
  assign phy_cs_o    = cs_q;
  assign grant_id_o  = gid_q;

endmodule

// File: tb/tb_hyper_trx_arbiter.sv
// Directed bench for hyper_trx_arbiter: default build, a three-chip build and a zero-gap build.
module tb_hyper_trx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [4:0]  shift;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [1:0]  req_write;
  logic [31:0] req_burst;
  logic        phy_ready;
  logic        phy_done;

  logic [1:0]  ready_a, ready_b, ready_g;
  logic        pvalid_a, pvalid_b, pvalid_g;
  logic [31:0] paddr_a, paddr_b, paddr_g;
  logic        pwrite_a, pwrite_b, pwrite_g;
  logic [15:0] pburst_a, pburst_b, pburst_g;
  logic [1:0]  cs_a, cs_g;
  logic [2:0]  cs_b;
  logic        gid_a, gid_b, gid_g;
  logic        busy_a, busy_b, busy_g;

  int checks = 0;
  int errors = 0;

  hyper_trx_arbiter #(.NumReq(2), .AddrWidth(32), .BurstWidth(16), .NumChips(2), .CsHiCycles(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cfg_cs_shift_i(shift), .req_valid_i(req_valid),
    .req_ready_o(ready_a), .req_addr_i(req_addr), .req_write_i(req_write), .req_burst_i(req_burst),
    .phy_valid_o(pvalid_a), .phy_ready_i(phy_ready), .phy_addr_o(paddr_a), .phy_write_o(pwrite_a),
    .phy_burst_o(pburst_a), .phy_cs_o(cs_a), .phy_done_i(phy_done), .grant_id_o(gid_a), .busy_o(busy_a));

  hyper_trx_arbiter #(.NumReq(2), .AddrWidth(32), .BurstWidth(16), .NumChips(3), .CsHiCycles(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cfg_cs_shift_i(shift), .req_valid_i(req_valid),
    .req_ready_o(ready_b), .req_addr_i(req_addr), .req_write_i(req_write), .req_burst_i(req_burst),
    .phy_valid_o(pvalid_b), .phy_ready_i(phy_ready), .phy_addr_o(paddr_b), .phy_write_o(pwrite_b),
    .phy_burst_o(pburst_b), .phy_cs_o(cs_b), .phy_done_i(phy_done), .grant_id_o(gid_b), .busy_o(busy_b));

  hyper_trx_arbiter #(.NumReq(2), .AddrWidth(32), .BurstWidth(16), .NumChips(2), .CsHiCycles(0)) dut_g (
    .clk_i(clk), .rst_ni(rst_n), .cfg_cs_shift_i(shift), .req_valid_i(req_valid),
    .req_ready_o(ready_g), .req_addr_i(req_addr), .req_write_i(req_write), .req_burst_i(req_burst),
    .phy_valid_o(pvalid_g), .phy_ready_i(phy_ready), .phy_addr_o(paddr_g), .phy_write_o(pwrite_g),
    .phy_burst_o(pburst_g), .phy_cs_o(cs_g), .phy_done_i(phy_done), .grant_id_o(gid_g), .busy_o(busy_g));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    shift     = 5'd20;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_burst = '0;
    phy_ready = 1'b0;
    phy_done  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (ready_a !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", ready_a); end
    checks++;
    if ({pvalid_a, busy_a, gid_a, pwrite_a} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {pvalid_a, busy_a, gid_a, pwrite_a});
    end
    checks++;
    if (cs_a !== 2'b00) begin errors++; $display("FAIL reset_cs: got %b want 00", cs_a); end
    checks++;
    if ({paddr_a, pburst_a} !== 48'h0) begin
      errors++; $display("FAIL reset_fields: got %h want 0", {paddr_a, pburst_a});
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_addr[31:0]  = 32'h8000_0040;
    req_burst[15:0] = 16'd8;
    req_valid       = 2'b01;
    #1;
    checks++;
    if (ready_a !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", ready_a); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if (pvalid_a !== 1'b1) begin errors++; $display("FAIL single_pvalid: got %b want 1", pvalid_a); end
    checks++;
    if (cs_a !== 2'b01) begin errors++; $display("FAIL single_cs: got %b want 01", cs_a); end
    checks++;
    if ({paddr_a, pwrite_a, pburst_a} !== {32'h8000_0040, 1'b0, 16'd8}) begin
      errors++; $display("FAIL single_fields: got %h/%b/%0d want 80000040/0/8", paddr_a, pwrite_a, pburst_a);
    end
    phy_ready = 1'b1;
    tick();
    phy_ready = 1'b0;
    #1;
    checks++;
    if ({pvalid_a, busy_a} !== 2'b01) begin
      errors++; $display("FAIL single_busy: got valid/busy %b want 01", {pvalid_a, busy_a});
    end
    phy_done = 1'b1;
    tick();
    phy_done = 1'b0;
    #1;
    checks++;
    if ({busy_a, cs_a} !== 3'b101) begin errors++; $display("FAIL single_gap1: got busy/cs %b want 101", {busy_a, cs_a}); end
    tick();
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL single_gap2: got busy %b want 1", busy_a); end
    tick();
    checks++;
    if ({busy_a, cs_a} !== 3'b000) begin errors++; $display("FAIL single_idle: got busy/cs %b want 000", {busy_a, cs_a}); end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    req_addr  = {32'h0000_2000, 32'h0000_1000};
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!pvalid_a && n < 10) begin tick(); n++; end
      checks++;
      if (!pvalid_a) begin
        errors++; $display("FAIL rr_timeout: txn %0d got no phy_valid within 10 cycles", k);
      end else if ({gid_a, paddr_a} !== {1'(k % 2), (k % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000}) begin
        errors++; $display("FAIL rr_grant: txn %0d got id %0d addr %h want id %0d", k, gid_a, paddr_a, k % 2);
      end
      phy_ready = 1'b1;
      tick();
      phy_ready = 1'b0;
      phy_done  = 1'b1;
      tick();
      phy_done  = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_chip_select();
    do_reset();
    req_addr[31:0] = 32'h8010_0000;
    req_valid      = 2'b01;
    tick();
    req_valid = 2'b00;
    shift     = 5'd0;
    #1;
    checks++;
    if ({cs_a, cs_b} !== 5'b10_010) begin
      errors++; $display("FAIL cs_bit20: got a=%b b=%b want a=10 b=010", cs_a, cs_b);
    end
    tick();
    checks++;
    if (cs_a !== 2'b10) begin errors++; $display("FAIL cs_shift_change: got %b want 10", cs_a); end
    do_reset();
    req_addr[31:0] = 32'h8030_0000;
    req_valid      = 2'b01;
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if ({cs_a, cs_b} !== 5'b10_100) begin
      errors++; $display("FAIL cs_clamp: got a=%b b=%b want a=10 b=100", cs_a, cs_b);
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_addr[63:32]  = 32'h1234_5678;
    req_write        = 2'b10;
    req_burst[31:16] = 16'h0020;
    req_valid        = 2'b10;
    #1;
    checks++;
    if (ready_a !== 2'b10) begin errors++; $display("FAIL stall_ready: got %b want 10", ready_a); end
    tick();
    req_valid       = 2'b00;
    req_addr[63:32] = 32'hDEAD_BEEF;
    req_write       = 2'b00;
    for (int i = 0; i < 5; i++) begin
      phy_done = (i == 2);
      #1;
      checks++;
      if ({pvalid_a, gid_a, paddr_a, pwrite_a, pburst_a} !== {1'b1, 1'b1, 32'h1234_5678, 1'b1, 16'h0020}) begin
        errors++; $display("FAIL stall_hold: cycle %0d got v=%b id=%b a=%h w=%b b=%h", i, pvalid_a, gid_a, paddr_a, pwrite_a, pburst_a);
      end
      tick();
    end
    phy_ready = 1'b1;
    phy_done  = 1'b1;
    tick();
    phy_ready = 1'b0;
    phy_done  = 1'b0;
    repeat (4) tick();
    checks++;
    if ({busy_a, pvalid_a} !== 2'b10) begin
      errors++; $display("FAIL stall_busy_wait: got busy/valid %b want 10", {busy_a, pvalid_a});
    end
    phy_done = 1'b1;
    tick();
    phy_done = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL stall_release: got busy %b want 0", busy_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_addr[31:0] = 32'h0000_0100;
    req_valid      = 2'b01;
    tick();
    phy_ready = 1'b1;
    tick();
    phy_ready = 1'b0;
    phy_done  = 1'b1;
    tick();
    phy_done = 1'b0;
    #1;
    checks++;
    if ({pvalid_g, busy_g, ready_g} !== 4'b0001) begin
      errors++; $display("FAIL b2b_idle: got valid/busy/ready %b want 0001", {pvalid_g, busy_g, ready_g});
    end
    tick();
    checks++;
    if (pvalid_g !== 1'b1) begin errors++; $display("FAIL b2b_reissue: got %b want 1", pvalid_g); end
    checks++;
    if ({pvalid_a, busy_a, ready_a} !== 4'b0100) begin
      errors++; $display("FAIL b2b_gap: got valid/busy/ready %b want 0100", {pvalid_a, busy_a, ready_a});
    end
    tick();
    #1;
    checks++;
    if ({busy_a, ready_a} !== 3'b001) begin
      errors++; $display("FAIL b2b_gap_end: got busy/ready %b want 001", {busy_a, ready_a});
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_addr  = {32'h0000_0000, 32'h0010_0000};
    req_valid = 2'b11;
    tick();
    phy_ready = 1'b1;
    tick();
    phy_ready = 1'b0;
    #1;
    checks++;
    if ({busy_a, cs_a} !== 3'b110) begin
      errors++; $display("FAIL mid_busy: got busy/cs %b want 110", {busy_a, cs_a});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pvalid_a, busy_a, cs_a, ready_a, gid_a} !== 7'b0) begin
      errors++; $display("FAIL mid_reset_out: got %b want 0000000", {pvalid_a, busy_a, cs_a, ready_a, gid_a});
    end
    checks++;
    if (paddr_a !== 32'h0) begin errors++; $display("FAIL mid_reset_addr: got %h want 0", paddr_a); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready_a !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got %b want 01", ready_a); end
    req_valid = 2'b00;
  endtask

  initial begin
    rst_n     = 1'b0;
    shift     = 5'd20;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_burst = '0;
    phy_ready = 1'b0;
    phy_done  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_chip_select();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
